timer_preset_editor: RTL
========================

// Module: timer_preset_editor
// PURPOSE
//  Button-driven BCD preset editor placed directly upstream of count_down_timer.
//  Operator enters edit mode, selects the HH/MM/SS field, steps it up or down, then confirms or cancels.
//  On confirm it drives hour/minute/second_bcd_out into the timer's *_bcd_in inputs and pulses set_timer for one cycle.
//  Also supplies display values and a field-blink flag to the 7-segment driver.
// PARAMETERS
//  MAX_HOUR      23  highest hour value (decimal, <=99); hours wrap 00..MAX_HOUR
//  BLINK_DIV     25_000_000  clk cycles per half blink period
//  REPEAT_DELAY  50_000_000  cycles inc/dec is held before auto-repeat starts (AUTO_REPEAT_EN only)
//  REPEAT_RATE   10_000_000  cycles between auto-repeat steps (AUTO_REPEAT_EN only)
// PORTS
//  clk             in   1  system clock
//  rst             in   1  asynchronous active-high reset
//  enter_edit      in   1  1-cycle pulse: start editing (ignored while editing)
//  next_field      in   1  1-cycle pulse: rotate field HH->MM->SS->HH
//  inc             in   1  debounced level: step field +1 (rising edge detected internally)
//  dec             in   1  debounced level: step field -1 (rising edge detected internally)
//  confirm         in   1  1-cycle pulse: commit working value
//  cancel          in   1  1-cycle pulse: discard working value
//  hour_bcd_out    out  8  committed hours, BCD -> count_down_timer.hour_bcd_in
//  minute_bcd_out  out  8  committed minutes, BCD -> minute_bcd_in
//  second_bcd_out  out  8  committed seconds, BCD -> second_bcd_in
//  set_timer       out  1  1-cycle load strobe -> count_down_timer.set_timer
//  disp_hour_bcd   out  8  working value while editing, else committed value
//  disp_min_bcd    out  8  same, minutes
//  disp_sec_bcd    out  8  same, seconds
//  editing         out  1  high in any EDIT_* state
//  field_sel       out  2  0=HH 1=MM 2=SS; 0 when idle
//  blink           out  1  toggles every BLINK_DIV cycles while editing; 0 when idle
// BEHAVIOUR
//  Reset: all BCD outputs 8'h00, set_timer=0, editing=0, field_sel=0, blink=0, state IDLE, blink counter 0.
//  All outputs are registered.
//  FSM: IDLE, EDIT_H, EDIT_M, EDIT_S.
//  - IDLE + enter_edit -> EDIT_H; working regs load committed value; blink counter cleared, blink=0.
//  - next_field: EDIT_H->EDIT_M->EDIT_S->EDIT_H.
//  - cancel (any EDIT_*) -> IDLE; working value discarded; committed value and outputs unchanged.
//  - confirm (any EDIT_*) with working != 00:00:00 -> IDLE; committed <= working.
//    On the next cycle set_timer=1 for exactly one cycle, with *_bcd_out already holding the new value.
//  - confirm with working == 00:00:00 is ignored: stay in the current state, no pulse.
//  - Same-cycle priority: cancel > confirm > next_field > inc/dec.
//  Steps:
//  - Each step is applied to the selected field only, in BCD.
//  - Minutes/seconds: 59+1 -> 00, 00-1 -> 59. Hours: MAX_HOUR+1 -> 00, 00-1 -> MAX_HOUR.
//  - Low digit carries/borrows into the high digit (09+1 -> 10, 10-1 -> 09). No invalid BCD is ever produced.
//  - inc and dec rising edges in the same cycle -> no change.
//  - inc/dec/next_field/confirm/cancel are ignored in IDLE.
//  - enter_edit is ignored in EDIT_*.
//  Latency: one step per rising edge; the working/display value updates one cycle after the edge is seen.
//  Reset asserted mid-edit: immediate return to the reset state; no set_timer pulse.
// CONFIGURATION
//  AUTO_REPEAT_EN defined:
//  - inc/dec held continuously for REPEAT_DELAY cycles after the initial step produces a further step.
//  - Further steps then follow every REPEAT_RATE cycles while held.
//  - Release, or a field change, clears the repeat counter.
//  - Both inc and dec held together -> no repeat.
//  AUTO_REPEAT_EN undefined: only the rising edge steps. Repeat counters and REPEAT_* logic are absent.
// TESTING (bench uses BLINK_DIV=4, REPEAT_DELAY=8, REPEAT_RATE=2)
//  1 Reset held then released -> all BCD outputs 00, set_timer=0, editing=0, blink=0 for 20 idle cycles.
//  2 enter_edit, 2x inc, next_field, 1x dec, next_field, 1x inc, confirm
//    -> exactly one set_timer pulse; outputs 02:59:01 on the pulse cycle.
//  3 Hour wrap: from 23 inc -> 00; from 00 dec -> 23; minute 09 inc -> 10; minute 10 dec -> 09.
//  4 Edit to 05:00:00, then cancel -> outputs keep the previous 02:59:01, no set_timer, editing=0.
//  5 confirm at 00:00:00 -> stays editing, no pulse. inc+dec same cycle -> no change. rst mid-edit -> reset state.
//  6 AUTO_REPEAT_EN: hold inc 20 cycles on SS from 00 -> 1 step at the edge, then steps at +8,+10,+12.. -> ends at 07.
//    Without the macro the same stimulus ends at 01.

Source files
------------

// File: rtl/timer_preset_editor.sv
`default_nettype none
// ============================================================================
//  Module   : timer_preset_editor
//  Purpose  : Button-driven HH:MM:SS BCD preset editor feeding count_down_timer.
//             Optional hold-to-repeat on inc/dec enabled by AUTO_REPEAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module timer_preset_editor #(
  parameter int MAX_HOUR  = 23,
  parameter int BLINK_DIV = 25_000_000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter_edit,
  input  logic       next_field,
  input  logic       inc,
  input  logic       dec,
  input  logic       confirm,
  input  logic       cancel,
  output logic [7:0] hour_bcd_out,
  output logic [7:0] minute_bcd_out,
  output logic [7:0] second_bcd_out,
  output logic       set_timer,
  output logic [7:0] disp_hour_bcd,
  output logic [7:0] disp_min_bcd,
  output logic [7:0] disp_sec_bcd,
  output logic       editing,
  output logic [1:0] field_sel,
  output logic       blink
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    EDIT_S = 2'd3
  } state_t;

  localparam logic [7:0] C_HOUR_MAX   = 8'(((MAX_HOUR / 10) << 4) | (MAX_HOUR % 10));
  localparam logic [7:0] C_MINSEC_MAX = 8'h59;
  localparam int         C_BLK_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [C_BLK_W-1:0] C_BLINK_LAST = C_BLK_W'(BLINK_DIV - 1);

  // Digit-wise BCD step; operands are always valid BCD so no correction pass is needed.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    logic [7:0] r;
    if (v >= vmax)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
    logic [7:0] r;
    if (v == 8'h00)
      r = vmax;
    else if (v[3:0] == 4'd0)
      r = {v[7:4] - 4'd1, 4'd9};
    else
      r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  state_t     r_state;
  state_t     w_state;
  logic [7:0] r_wh;
  logic [7:0] r_wm;
  logic [7:0] r_ws;
  logic [7:0] w_wh;
  logic [7:0] w_wm;
  logic [7:0] w_ws;
  logic       r_inc_d;
  logic       r_dec_d;
  logic       w_inc_rise;
  logic       w_dec_rise;
  logic       w_up;
  logic       w_dn;
  logic       w_commit;
  logic       w_work_zero;
  logic       w_editing;
  logic [1:0] w_field_sel;
  logic [C_BLK_W-1:0] r_blink_cnt;

  assign w_inc_rise  = inc & ~r_inc_d;
  assign w_dec_rise  = dec & ~r_dec_d;
  assign w_work_zero = (r_wh == 8'h00) && (r_wm == 8'h00) && (r_ws == 8'h00);

`ifdef AUTO_REPEAT_EN
  localparam int C_REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int C_REP_W   = $clog2(C_REP_MAX + 1);
  localparam logic [C_REP_W-1:0] C_DLY_LAST  = C_REP_W'(REPEAT_DELAY - 1);
  localparam logic [C_REP_W-1:0] C_RATE_LAST = C_REP_W'(REPEAT_RATE - 1);

  logic [C_REP_W-1:0] r_rep_cnt;
  logic               r_rep_fast;
  logic               w_hold_inc;
  logic               w_hold_dec;
  logic               w_rep_clr;
  logic               w_rep_fire;

  // A hold is only a continuation of an earlier press; the edge cycle itself steps normally.
  assign w_hold_inc = inc & r_inc_d & ~dec;
  assign w_hold_dec = dec & r_dec_d & ~inc;
  assign w_rep_clr  = (r_state == IDLE) | next_field | ~(w_hold_inc | w_hold_dec);
  assign w_rep_fire = ~w_rep_clr &
                      (r_rep_cnt == (r_rep_fast ? C_RATE_LAST : C_DLY_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep_cnt  <= '0;
      r_rep_fast <= 1'b0;
    end else if (w_rep_clr) begin
      r_rep_cnt  <= '0;
      r_rep_fast <= 1'b0;
    end else if (w_rep_fire) begin
      r_rep_cnt  <= '0;
      r_rep_fast <= 1'b1;
    end else begin
      r_rep_cnt  <= r_rep_cnt + 1'b1;
    end
  end

  assign w_up = (w_inc_rise & ~w_dec_rise) | (w_rep_fire & w_hold_inc);
  assign w_dn = (w_dec_rise & ~w_inc_rise) | (w_rep_fire & w_hold_dec);
`else
  assign w_up = w_inc_rise & ~w_dec_rise;
  assign w_dn = w_dec_rise & ~w_inc_rise;
`endif

  // Next-state / working-value selection; priority cancel > confirm > next_field > step.
  always_comb begin
    w_state  = r_state;
    w_wh     = r_wh;
    w_wm     = r_wm;
    w_ws     = r_ws;
    w_commit = 1'b0;
    case (r_state)
      IDLE: begin
        if (enter_edit) begin
          w_state = EDIT_H;
          w_wh    = hour_bcd_out;
          w_wm    = minute_bcd_out;
          w_ws    = second_bcd_out;
        end
      end
      default: begin
        if (cancel) begin
          w_state = IDLE;
        end else if (confirm && !w_work_zero) begin
          w_state  = IDLE;
          w_commit = 1'b1;
        end else if (next_field) begin
          case (r_state)
            EDIT_H:  w_state = EDIT_M;
            EDIT_M:  w_state = EDIT_S;
            default: w_state = EDIT_H;
          endcase
        end else if (w_up || w_dn) begin
          case (r_state)
            EDIT_H:  w_wh = w_up ? bcd_inc(r_wh, C_HOUR_MAX)   : bcd_dec(r_wh, C_HOUR_MAX);
            EDIT_M:  w_wm = w_up ? bcd_inc(r_wm, C_MINSEC_MAX) : bcd_dec(r_wm, C_MINSEC_MAX);
            default: w_ws = w_up ? bcd_inc(r_ws, C_MINSEC_MAX) : bcd_dec(r_ws, C_MINSEC_MAX);
          endcase
        end
      end
    endcase
  end

  assign w_editing = (w_state != IDLE);

  always_comb begin
    w_field_sel = 2'd0;
    case (w_state)
      EDIT_M:  w_field_sel = 2'd1;
      EDIT_S:  w_field_sel = 2'd2;
      default: w_field_sel = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_wh           <= 8'h00;
      r_wm           <= 8'h00;
      r_ws           <= 8'h00;
      r_inc_d        <= 1'b0;
      r_dec_d        <= 1'b0;
      hour_bcd_out   <= 8'h00;
      minute_bcd_out <= 8'h00;
      second_bcd_out <= 8'h00;
      set_timer      <= 1'b0;
      disp_hour_bcd  <= 8'h00;
      disp_min_bcd   <= 8'h00;
      disp_sec_bcd   <= 8'h00;
      editing        <= 1'b0;
      field_sel      <= 2'd0;
      blink          <= 1'b0;
      r_blink_cnt    <= '0;
    end else begin
      r_state   <= w_state;
      r_wh      <= w_wh;
      r_wm      <= w_wm;
      r_ws      <= w_ws;
      r_inc_d   <= inc;
      r_dec_d   <= dec;
      set_timer <= w_commit;
      editing   <= w_editing;
      field_sel <= w_field_sel;

      if (w_commit) begin
        hour_bcd_out   <= r_wh;
        minute_bcd_out <= r_wm;
        second_bcd_out <= r_ws;
      end

      if (w_editing) begin
        disp_hour_bcd <= w_wh;
        disp_min_bcd  <= w_wm;
        disp_sec_bcd  <= w_ws;
      end else if (w_commit) begin
        disp_hour_bcd <= r_wh;
        disp_min_bcd  <= r_wm;
        disp_sec_bcd  <= r_ws;
      end else begin
        disp_hour_bcd <= hour_bcd_out;
        disp_min_bcd  <= minute_bcd_out;
        disp_sec_bcd  <= second_bcd_out;
      end

      // Blink phase restarts on every entry into edit mode.
      if (!w_editing || (r_state == IDLE)) begin
        r_blink_cnt <= '0;
        blink       <= 1'b0;
      end else if (r_blink_cnt == C_BLINK_LAST) begin
        r_blink_cnt <= '0;
        blink       <= ~blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
